upower_alu_64b: RTL and testbench
=================================

# upower_alu_64b

Registered 64-bit integer ALU for the uPower datapath with its operation decoder built in. The datapath supplies an ALU-op class, the 6-bit primary opcode (PO) and the 9-bit extended opcode (XO). The block decodes these into a 4-bit ALU control code and computes the result and flags on two 64-bit operands. The DS-format load/store path uses it for effective-address generation (RA + sign-extended DS); the X/XO/D-format paths use it for arithmetic and logic.

## Interface
- No parameters; width fixed at 64.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all registered outputs.
- alu_op  in  2  operation class: 00 load/store, 01 compare/branch, 10 X/XO-form (decode XO), 11 D-form immediate (decode PO).
- po  in  6  primary opcode.
- xo  in  9  extended opcode (low 9 bits of the XO field).
- a  in  64  operand A (RA data).
- b  in  64  operand B (RB data or sign-extended immediate).
- alu_ctrl  out  4  decoded control code, combinational.
- result  out  64  registered result.
- overflow  out  1  registered signed overflow.
- carryout  out  1  registered carry (CA).
- zero  out  1  registered, 1 when result is all zeros.

## Operation
- Control codes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB (a-b), 0111 SLT, 1100 NOR, 1101 NAND.
- Decode by alu_op:
  - 00 → ADD (po/xo ignored).
  - 01 → SUB.
  - 10 → by xo: 266 ADD, 40 SUB, 28 AND, 444 OR, 316 XOR, 124 NOR, 476 NAND.
  - 11 → by po: 14 ADD (addi), 28 AND (andi.), 24 OR (ori), 26 XOR (xori).
  - Any undefined xo/po → ADD.
- ADD: a+b mod 2^64.
  - carryout = carry out of bit 63.
  - overflow = a[63]==b[63] && result[63]!=a[63].
- SUB: a + ~b + 1.
  - carryout = carry out of bit 63 (1 when a ≥ b unsigned, i.e. no borrow).
  - overflow = a[63]!=b[63] && result[63]!=a[63].
- SLT: result = 64'd1 if a<b signed, else 0; flags as for SUB except result.
- Logic ops: bitwise; overflow = 0, carryout = 0.
- zero = (result == 0) for every op.

## Timing
- alu_ctrl is purely combinational from alu_op/po/xo; no latency.
- result, overflow, carryout and zero are registered: inputs sampled at rising edge N appear after edge N. One cycle latency, new operation accepted every cycle, no handshake.
- reset asserted (any time, including mid-stream) immediately forces result = 0, overflow = 0, carryout = 0, zero = 0.
- First edge after reset deasserts loads the live computation; there is no stale state.
- Inputs held constant produce a constant output from the next edge.

## Structure
- Shared package: control-code constants (ALU_AND … ALU_NAND), alu_op class encodings, and PO/XO opcode constants (ADD_XO=266, SUBF_XO=40, AND_XO=28, OR_XO=444, XOR_XO=316, NOR_XO=124, NAND_XO=476, ADDI_PO=14, ANDI_PO=28, ORI_PO=24, XORI_PO=26, LD_PO=58, STD_PO=62).
- One natural sub-module: alu_control_unit (combinational decoder: alu_op, po, xo → alu_ctrl).
- Top contains the combinational 64-bit datapath (shared adder with B-invert for ADD/SUB/SLT) plus the output register.

## Test plan
- Reset: assert reset with a=5, b=7, alu_op=00 → all registered outputs 0 asynchronously; deassert → next edge result=12, zero=0.
- Load/store EA: alu_op=00, a=3, b=64'hFFFF_FFFF_FFFF_FFFC (DS=-4) → alu_ctrl=0010, result=64'hFFFF_FFFF_FFFF_FFFF, carryout=0, overflow=0.
- Add overflow/carry: alu_op=10, xo=266, a=64'h7FFF_FFFF_FFFF_FFFF, b=1 → result=64'h8000_0000_0000_0000, overflow=1, carryout=0; then a=b=64'hFFFF_FFFF_FFFF_FFFF → result=-2, carryout=1, overflow=0.
- Subtract/zero: alu_op=01, a=b=42 → alu_ctrl=0110, result=0, zero=1, carryout=1; a=1, b=2 → result=-1, carryout=0.
- Logic decode: alu_op=10 with a=64'hF0F0, b=64'hFF00: xo=28 → F000; xo=444 → FFF0; xo=316 → 0FF0; xo=124 → ~FFF0; xo=476 → ~F000; alu_op=11 po=24 → FFF0.
- Default decode: alu_op=10, xo=1 → alu_ctrl=0010 (ADD); back-to-back ops on consecutive cycles each appear exactly one cycle later.

Source files
------------

// File: rtl/upower_alu_64b_pkg.sv
// Shared constants for the uPower 64-bit ALU: control codes, op classes and opcodes.
package upower_alu_64b_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_NOR  = 4'b1100,
        ALU_NAND = 4'b1101
    } alu_ctrl_e;

    localparam logic [1:0] OP_LDST = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_XFORM = 2'b10;
    localparam logic [1:0] OP_DFORM = 2'b11;

    localparam logic [8:0] ADD_XO  = 9'd266;
    localparam logic [8:0] SUBF_XO = 9'd40;
    localparam logic [8:0] AND_XO  = 9'd28;
    localparam logic [8:0] OR_XO   = 9'd444;
    localparam logic [8:0] XOR_XO  = 9'd316;
    localparam logic [8:0] NOR_XO  = 9'd124;
    localparam logic [8:0] NAND_XO = 9'd476;

    localparam logic [5:0] ADDI_PO = 6'd14;
    localparam logic [5:0] ANDI_PO = 6'd28;
    localparam logic [5:0] ORI_PO  = 6'd24;
    localparam logic [5:0] XORI_PO = 6'd26;
    localparam logic [5:0] LD_PO   = 6'd58;
    localparam logic [5:0] STD_PO  = 6'd62;

endpackage

// File: rtl/upower_alu_64b_alu_control_unit.sv
// Combinational decoder from op class / PO / XO to the 4-bit ALU control code.
module upower_alu_64b_alu_control_unit
    import upower_alu_64b_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] po,
    input  logic [8:0] xo,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        unique case (alu_op)
            OP_LDST: alu_ctrl = ALU_ADD;
            OP_CMP:  alu_ctrl = ALU_SUB;
            OP_XFORM: begin
                case (xo)
                    ADD_XO:  alu_ctrl = ALU_ADD;
                    SUBF_XO: alu_ctrl = ALU_SUB;
                    AND_XO:  alu_ctrl = ALU_AND;
                    OR_XO:   alu_ctrl = ALU_OR;
                    XOR_XO:  alu_ctrl = ALU_XOR;
                    NOR_XO:  alu_ctrl = ALU_NOR;
                    NAND_XO: alu_ctrl = ALU_NAND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            OP_DFORM: begin
                case (po)
                    ADDI_PO: alu_ctrl = ALU_ADD;
                    ANDI_PO: alu_ctrl = ALU_AND;
                    ORI_PO:  alu_ctrl = ALU_OR;
                    XORI_PO: alu_ctrl = ALU_XOR;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/upower_alu_64b.sv
// Registered 64-bit uPower ALU: decoder, shared add/sub datapath, output register.
module upower_alu_64b
    import upower_alu_64b_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  po,
    input  logic [8:0]  xo,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [3:0]  alu_ctrl,
    output logic [63:0] result,
    output logic        overflow,
    output logic        carryout,
    output logic        zero
);

    logic        sub;
    logic [63:0] b_op;
    logic [64:0] sum;
    logic        add_ovf;
    logic [63:0] res_d;
    logic        ovf_d;
    logic        cry_d;

    upower_alu_64b_alu_control_unit u_ctrl (
        .alu_op   (alu_op),
        .po       (po),
        .xo       (xo),
        .alu_ctrl (alu_ctrl)
    );

    // One adder serves ADD, SUB and SLT; subtract is a + ~b + 1.
    // The overflow test on b_op covers both ADD and SUB since b_op[63] is inverted for SUB.
    always_comb begin
        sub     = (alu_ctrl == ALU_SUB) || (alu_ctrl == ALU_SLT);
        b_op    = sub ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_op} + {64'd0, sub};
        add_ovf = (a[63] == b_op[63]) && (sum[63] != a[63]);
        res_d   = sum[63:0];
        ovf_d   = add_ovf;
        cry_d   = sum[64];
        case (alu_ctrl)
            ALU_AND:  begin res_d = a & b;    ovf_d = 1'b0; cry_d = 1'b0; end
            ALU_OR:   begin res_d = a | b;    ovf_d = 1'b0; cry_d = 1'b0; end
            ALU_XOR:  begin res_d = a ^ b;    ovf_d = 1'b0; cry_d = 1'b0; end
            ALU_NOR:  begin res_d = ~(a | b); ovf_d = 1'b0; cry_d = 1'b0; end
            ALU_NAND: begin res_d = ~(a & b); ovf_d = 1'b0; cry_d = 1'b0; end
            ALU_SLT:  res_d = {63'd0, sum[63] ^ add_ovf};
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result   <= 64'd0;
            overflow <= 1'b0;
            carryout <= 1'b0;
            zero     <= 1'b0;
        end else begin
            result   <= res_d;
            overflow <= ovf_d;
            carryout <= cry_d;
            zero     <= (res_d == 64'd0);
        end
    end

endmodule

// File: tb/tb_upower_alu_64b.sv
// Directed self-checking bench for upower_alu_64b with hand-computed expectations.
module tb_upower_alu_64b;

    logic        clk;
    logic        reset;
    logic [1:0]  alu_op;
    logic [5:0]  po;
    logic [8:0]  xo;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  alu_ctrl;
    logic [63:0] result;
    logic        overflow;
    logic        carryout;
    logic        zero;

    int errors = 0;
    int checks = 0;

    upower_alu_64b dut (
        .clk      (clk),
        .reset    (reset),
        .alu_op   (alu_op),
        .po       (po),
        .xo       (xo),
        .a        (a),
        .b        (b),
        .alu_ctrl (alu_ctrl),
        .result   (result),
        .overflow (overflow),
        .carryout (carryout),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // flags packed as {overflow, carryout, zero}
    task automatic chkf(input string tag, input logic [2:0] exp);
        checks++;
        assert ({overflow, carryout, zero} === exp) else begin
            errors++;
            $error("FAIL %s: got vcz=%b expected vcz=%b", tag, {overflow, carryout, zero}, exp);
        end
    endtask

    task automatic chkc(input string tag, input logic [3:0] exp);
        checks++;
        assert (alu_ctrl === exp) else begin
            errors++;
            $error("FAIL %s: got ctrl=%b expected ctrl=%b", tag, alu_ctrl, exp);
        end
    endtask

    // apply on the falling edge, then sample 1 time unit after the next rising edge
    task automatic apply(input logic [1:0] op, input logic [5:0] p, input logic [8:0] x,
                         input logic [63:0] aa, input logic [63:0] bb);
        @(negedge clk);
        alu_op = op; po = p; xo = x; a = aa; b = bb;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; alu_op = 2'b00; po = 6'd0; xo = 9'd0; a = 64'd5; b = 64'd7;
        #2;
        chk("rst_result", result, 64'd0);
        chkf("rst_flags", 3'b000);
        tick();
        chk("rst_held", result, 64'd0);

        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("rst_release", result, 64'd12);
        chkf("rst_release_flags", 3'b000);

        #2;
        reset = 1'b1;
        #1;
        chk("rst_async", result, 64'd0);
        chkf("rst_async_flags", 3'b000);
        #1;
        reset = 1'b0;

        apply(2'b00, 6'd58, 9'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC);
        chkc("ea_ctrl", 4'b0010);
        tick();
        chk("ea_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        chkf("ea_flags", 3'b000);

        apply(2'b10, 6'd31, 9'd266, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        chkc("add_ctrl", 4'b0010);
        tick();
        chk("add_ovf_result", result, 64'h8000_0000_0000_0000);
        chkf("add_ovf_flags", 3'b100);

        apply(2'b10, 6'd31, 9'd266, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("add_cry_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
        chkf("add_cry_flags", 3'b010);

        apply(2'b10, 6'd31, 9'd28, 64'hF0F0, 64'hFF00);
        chkc("and_ctrl", 4'b0000);
        tick();
        chk("and_result", result, 64'hF000);
        chkf("and_flags", 3'b000);

        apply(2'b10, 6'd31, 9'd444, 64'hF0F0, 64'hFF00);
        chkc("or_ctrl", 4'b0001);
        tick();
        chk("or_result", result, 64'hFFF0);

        apply(2'b10, 6'd31, 9'd316, 64'hF0F0, 64'hFF00);
        chkc("xor_ctrl", 4'b0011);
        tick();
        chk("xor_result", result, 64'h0FF0);

        apply(2'b10, 6'd31, 9'd124, 64'hF0F0, 64'hFF00);
        chkc("nor_ctrl", 4'b1100);
        tick();
        chk("nor_result", result, 64'hFFFF_FFFF_FFFF_000F);
        chkf("nor_flags", 3'b000);

        apply(2'b10, 6'd31, 9'd476, 64'hF0F0, 64'hFF00);
        chkc("nand_ctrl", 4'b1101);
        tick();
        chk("nand_result", result, 64'hFFFF_FFFF_FFFF_0FFF);

        apply(2'b11, 6'd24, 9'd0, 64'hF0F0, 64'hFF00);
        chkc("ori_ctrl", 4'b0001);
        tick();
        chk("ori_result", result, 64'hFFF0);

        apply(2'b11, 6'd28, 9'd0, 64'hF0F0, 64'hFF00);
        chkc("andi_ctrl", 4'b0000);
        tick();
        chk("andi_result", result, 64'hF000);

        apply(2'b01, 6'd0, 9'd0, 64'd42, 64'd42);
        chkc("sub_ctrl", 4'b0110);
        tick();
        chk("sub_eq_result", result, 64'd0);
        chkf("sub_eq_flags", 3'b011);

        apply(2'b01, 6'd0, 9'd0, 64'd1, 64'd2);
        tick();
        chk("sub_lt_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        chkf("sub_lt_flags", 3'b000);

        apply(2'b10, 6'd0, 9'd1, 64'd100, 64'd23);
        chkc("dflt_ctrl", 4'b0010);
        tick();
        chk("dflt_result", result, 64'd123);

        // back-to-back: change inputs right after an edge, output must lag by one cycle
        apply(2'b10, 6'd0, 9'd266, 64'd10, 64'd20);
        tick();
        chk("b2b_first", result, 64'd30);
        alu_op = 2'b10; xo = 9'd40; a = 64'd10; b = 64'd20;
        #1;
        chk("b2b_hold", result, 64'd30);
        tick();
        chk("b2b_second", result, 64'hFFFF_FFFF_FFFF_FFF6);
        chkf("b2b_second_flags", 3'b000);
        alu_op = 2'b11; po = 6'd26; a = 64'hF0F0; b = 64'hFF00;
        tick();
        chk("b2b_third", result, 64'h0FF0);
        tick();
        chk("steady", result, 64'h0FF0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
